sync_fifo_v2: RTL

//   Parametrised single-clock FIFO; successor to the fixed 32x512 sync FIFO.

---
 rtl/sync_fifo_v2.sv | 138 +++++++++++++
 1 files changed

// File: rtl/sync_fifo_v2.sv
// sync_fifo_v2
//   Parametrised single-clock FIFO. It has a selectable read mode:
//   Standard mode uses a registered read with 1-cycle latency.
//   FWFT mode is first-word fall-through.
//   It also provides an occupancy count, registered watermark flags and
//   overflow/underflow error pulses.
//
// Ports
//   clk           clock, all logic on rising edge
//   rst           synchronous active-high reset
//   wr_en/wr_data write request and data
//   rd_en         read request (pop / acknowledge in FWFT)
//   rd_data       read data
//   rd_valid      rd_data holds a valid word
//   count         words stored, 0..DATA_DEPTH
//   full/empty    count == DATA_DEPTH / count == 0
//   almost_full   count >= AFULL_THRESH
//   almost_empty  count <= AEMPTY_THRESH
//   overflow      1-cycle pulse, write rejected while full
//   underflow     1-cycle pulse, read rejected while empty
module sync_fifo_v2 #(
    parameter int DATA_WIDTH    = 32,
    parameter int DATA_DEPTH    = 512,
    parameter int FWFT          = 0,
    parameter int AFULL_THRESH  = 480,
    parameter int AEMPTY_THRESH = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_en,
    input  logic [DATA_WIDTH-1:0]       wr_data,
    input  logic                        rd_en,
    output logic [DATA_WIDTH-1:0]       rd_data,
    output logic                        rd_valid,
    output logic [$clog2(DATA_DEPTH):0] count,
    output logic                        full,
    output logic                        empty,
    output logic                        almost_full,
    output logic                        almost_empty,
    output logic                        overflow,
    output logic                        underflow
);

    localparam int AW = $clog2(DATA_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DATA_DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AFULL_THRESH);
    localparam logic [CW-1:0] AE_C    = CW'(AEMPTY_THRESH);

    logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [AW-1:0]         rd_ptr_nxt;
    logic [CW-1:0]         count_nxt;
    logic                  do_wr;
    logic                  do_rd;

    // Acceptance uses the registered flags, so a read at full and a write at
    // empty still go through in a same-cycle wr/rd pair.
    assign do_wr      = wr_en && !full;
    assign do_rd      = rd_en && !empty;
    assign rd_ptr_nxt = do_rd ? rd_ptr + AW'(1) : rd_ptr;

    always_comb begin
        count_nxt = count;
        case ({do_wr, do_rd})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    // Storage is not reset; writes are blocked on the reset edge.
    always_ff @(posedge clk) begin
        if (!rst && do_wr)
            mem[wr_ptr] <= wr_data;
    end

    // The flags are computed from the next-state count, so they line up with count.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (do_wr)
                wr_ptr <= wr_ptr + AW'(1);
            rd_ptr       <= rd_ptr_nxt;
            count        <= count_nxt;
            full         <= (count_nxt == DEPTH_C);
            empty        <= (count_nxt == '0);
            almost_full  <= (count_nxt >= AF_C);
            almost_empty <= (count_nxt <= AE_C);
            overflow     <= wr_en && full;
            underflow    <= rd_en && empty;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // The head word is pre-registered for the next cycle. Suppose the
            // new head is the slot being written this edge. This happens when
            // the FIFO is empty after the read. In that case the word comes
            // from wr_data, because mem does not hold it yet.
            logic bypass;
            assign bypass = do_wr && (rd_ptr_nxt == wr_ptr);

            always_ff @(posedge clk) begin
                if (rst) begin
                    rd_data  <= '0;
                    rd_valid <= 1'b0;
                end else begin
                    rd_valid <= (count_nxt != '0);
                    if (count_nxt != '0)
                        rd_data <= bypass ? wr_data : mem[rd_ptr_nxt];
                end
            end
        end else begin : g_std
            always_ff @(posedge clk) begin
                if (rst) begin
                    rd_data  <= '0;
                    rd_valid <= 1'b0;
                end else begin
                    rd_valid <= do_rd;
                    if (do_rd)
                        rd_data <= mem[rd_ptr];
                end
            end
        end
    endgenerate

endmodule
